sb_tx_fifo: RTL and testbench

Sideband TX FIFO between the RDI encoder and the sideband serializer. It buffers 64-bit encoded sideband packets and supports retracting the most recently written packet when the encoder detects an error late. It hands the head packet to the serializer with a valid/done handshake. On every pop it exposes the popped packet and a read pulse so the credit-loop controller can track credits by source ID.

---
 rtl/sb_tx_fifo.sv | 109 ++++++++++
 tb/tb_sb_tx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_fifo.sv
// Sideband TX FIFO: buffers 64-bit encoded packets, supports retracting the last write,
// and pops on a rising edge of the serializer done level. Option macro: SB_TX_FIFO_ZERO_DROP_EN.
module sb_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_write_en,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_delete_data,
    input  logic             i_ser_done,
    output logic             o_fifo_full,
    output logic             o_fifo_empty,
    output logic             o_ser_valid,
    output logic [WIDTH-1:0] o_fifo_data,
    output logic             o_ser_done_sampled,
    output logic             o_dont_send_zeros
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             del_ok_q, del_ok_d;
    logic             done_d1_q;
    logic             pop_q, pop_d;

    logic             full, empty, zero_head, del_elig, head_avail;
    logic             wr_en, grow, shrink;
    logic [PTR_W-1:0] wr_addr;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign o_fifo_data = mem_q[rd_ptr_q];

`ifdef SB_TX_FIFO_ZERO_DROP_EN
    assign zero_head = !empty && (o_fifo_data == '0);
`else
    assign zero_head = 1'b0;
`endif

    assign o_fifo_full        = full;
    assign o_fifo_empty       = empty;
    assign o_dont_send_zeros  = zero_head;
    assign o_ser_valid        = !empty && !zero_head;
    assign o_ser_done_sampled = pop_q;

    // An entry already being popped this cycle must not be counted as a fresh head.
    assign head_avail = pop_q ? (count_q >= CNT_W'(2)) : !empty;
    assign del_elig   = i_delete_data && (count_q >= CNT_W'(2)) && del_ok_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        del_ok_d = del_ok_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        grow     = 1'b0;
        shrink   = 1'b0;
        if (i_write_en && del_elig) begin
            // Replace: overwrite the retracted slot, occupancy unchanged.
            wr_en   = 1'b1;
            wr_addr = wr_ptr_q - PTR_W'(1);
        end else if (del_elig) begin
            wr_ptr_d = wr_ptr_q - PTR_W'(1);
            del_ok_d = 1'b0;
            shrink   = 1'b1;
        end else if (i_write_en && !full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            del_ok_d = 1'b1;
            grow     = 1'b1;
        end
        count_d  = count_q + CNT_W'(grow) - CNT_W'(shrink) - CNT_W'(pop_q);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_q);
        pop_d    = head_avail && ((i_ser_done && !done_d1_q) || (zero_head && !pop_q));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            del_ok_q  <= 1'b0;
            done_d1_q <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            del_ok_q  <= del_ok_d;
            done_d1_q <= i_ser_done;
            pop_q     <= pop_d;
        end
    end

    // NOTE: the array is reset because the head is visible on o_fifo_data and must read 0 after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= i_data;
        end
    end

endmodule

// File: tb/tb_sb_tx_fifo.sv
// Scoreboard bench for sb_tx_fifo: the driver updates an expected-content queue,
// a negedge monitor compares every popped packet against it.
module tb_sb_tx_fifo;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_write_en = 1'b0;
    logic [63:0] i_data = '0;
    logic        i_delete_data = 1'b0;
    logic        i_ser_done = 1'b0;
    logic        o_fifo_full, o_fifo_empty, o_ser_valid, o_ser_done_sampled, o_dont_send_zeros;
    logic [63:0] o_fifo_data;

    int checks = 0;
    int errors = 0;
    int got_pulses = 0;
    int exp_pulses = 0;
    logic [63:0] exp_q[$];
    logic model_del_ok = 1'b0;
    logic prev_done = 1'b0;

    sb_tx_fifo #(.DEPTH(DEPTH), .WIDTH(64)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_write_en(i_write_en), .i_data(i_data),
        .i_delete_data(i_delete_data), .i_ser_done(i_ser_done),
        .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty), .o_ser_valid(o_ser_valid),
        .o_fifo_data(o_fifo_data), .o_ser_done_sampled(o_ser_done_sampled),
        .o_dont_send_zeros(o_dont_send_zeros)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and apply its effect to the expected contents.
    task automatic cyc(input logic we, input logic del, input logic done, input logic [63:0] d);
        int sz;
        logic elig;
        sz   = exp_q.size();
        elig = del && (sz >= 2) && model_del_ok;
        if (we && elig) begin
            exp_q[sz-1] = d;
        end else if (elig) begin
            void'(exp_q.pop_back());
            model_del_ok = 1'b0;
        end else if (we && sz < DEPTH) begin
            exp_q.push_back(d);
            model_del_ok = 1'b1;
        end
        if (done && !prev_done && sz != 0) exp_pulses++;
        prev_done     = done;
        i_write_en    = we;
        i_delete_data = del;
        i_ser_done    = done;
        i_data        = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr(input logic [63:0] d);
        cyc(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b1, '0);
        idle();
    endtask

    // Monitor: every pop pulse must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (i_rst_n && o_ser_done_sampled) begin
            got_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 64'd1, 64'd0);
            end else begin
                check("pop_data", o_fifo_data, exp_q[0]);
`ifdef SB_TX_FIFO_ZERO_DROP_EN
                check("pop_dont_send", {63'd0, o_dont_send_zeros}, {63'd0, exp_q[0] == 64'd0});
`else
                check("pop_dont_send", {63'd0, o_dont_send_zeros}, 64'd0);
`endif
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_empty", {63'd0, o_fifo_empty}, 64'd1);
        check("rst_full", {63'd0, o_fifo_full}, 64'd0);
        check("rst_valid", {63'd0, o_ser_valid}, 64'd0);
        check("rst_data", o_fifo_data, 64'd0);
        check("rst_sampled", {63'd0, o_ser_done_sampled}, 64'd0);
        check("rst_dont_send", {63'd0, o_dont_send_zeros}, 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Single write, valid next cycle, then pop.
        wr(64'h0000_0000_0000_00A5);
        check("wr_valid", {63'd0, o_ser_valid}, 64'd1);
        check("wr_not_empty", {63'd0, o_fifo_empty}, 64'd0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("pulse_n1", {63'd0, o_ser_done_sampled}, 64'd1);
        idle();
        check("empty_after_pop", {63'd0, o_fifo_empty}, 64'd1);

        // Fill, overflow write dropped, drain in order.
        for (int i = 1; i <= DEPTH; i++) wr(64'h1111_0000_0000_0000 + 64'(i));
        check("full", {63'd0, o_fifo_full}, 64'd1);
        wr(64'h1111_0000_0000_0005);
        check("full_after_drop", {63'd0, o_fifo_full}, 64'd1);
        for (int i = 0; i < DEPTH; i++) pop();
        check("drained", {63'd0, o_fifo_empty}, 64'd1);

        // Delete the last write, then a delete at count 1 is ignored.
        wr(64'h2222_0000_0000_0001);
        wr(64'h2222_0000_0000_0002);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        pop();
        check("del_empty", {63'd0, o_fifo_empty}, 64'd1);

        // Double delete only retracts once.
        wr(64'h3333_0000_0000_0001);
        wr(64'h3333_0000_0000_0002);
        wr(64'h3333_0000_0000_0003);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        pop();
        check("dbl_del_one_left", {63'd0, o_fifo_empty}, 64'd0);
        pop();
        check("dbl_del_empty", {63'd0, o_fifo_empty}, 64'd1);

        // Write together with delete replaces the last entry.
        wr(64'h4444_0000_0000_0001);
        wr(64'h4444_0000_0000_0002);
        cyc(1'b1, 1'b1, 1'b0, 64'h4444_0000_0000_0003);
        pop();
        pop();
        check("replace_empty", {63'd0, o_fifo_empty}, 64'd1);

        // Full, pop, write in the pulse cycle is dropped.
        for (int i = 1; i <= DEPTH; i++) wr(64'h5555_0000_0000_0000 + 64'(i));
        cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 1'b0, 64'h5555_0000_0000_00FF);
        check("full_pop_not_full", {63'd0, o_fifo_full}, 64'd0);
        for (int i = 0; i < DEPTH - 1; i++) pop();
        check("full_pop_empty", {63'd0, o_fifo_empty}, 64'd1);

        // Held done level gives exactly one pop.
        wr(64'h6666_0000_0000_0001);
        wr(64'h6666_0000_0000_0002);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, '0);
        check("held_one_pop", {63'd0, o_fifo_empty}, 64'd0);
        idle();
        pop();
        check("held_empty", {63'd0, o_fifo_empty}, 64'd1);

        // Rising edge while empty is ignored (monitor flags any pulse).
        pop();
        check("edge_empty", {63'd0, o_fifo_empty}, 64'd1);

`ifdef SB_TX_FIFO_ZERO_DROP_EN
        wr(64'd0);
        check("zero_dont_send", {63'd0, o_dont_send_zeros}, 64'd1);
        check("zero_not_valid", {63'd0, o_ser_valid}, 64'd0);
        exp_pulses++;
        wr(64'h7777_0000_0000_0001);
        check("zero_pulse", {63'd0, o_ser_done_sampled}, 64'd1);
        idle();
        check("zero_next_valid", {63'd0, o_ser_valid}, 64'd1);
        check("zero_next_head", o_fifo_data, 64'h7777_0000_0000_0001);
        pop();
`else
        wr(64'd0);
        check("zero_valid", {63'd0, o_ser_valid}, 64'd1);
        check("zero_dont_send", {63'd0, o_dont_send_zeros}, 64'd0);
        pop();
`endif
        check("zero_empty", {63'd0, o_fifo_empty}, 64'd1);

        // Reset in the middle of a pop: contents cleared, no pulse.
        wr(64'h8888_0000_0000_0001);
        i_ser_done = 1'b1;
        #2;
        i_rst_n = 1'b0;
        exp_q.delete();
        model_del_ok = 1'b0;
        @(posedge i_clk);
        #1;
        check("rst_mid_empty", {63'd0, o_fifo_empty}, 64'd1);
        check("rst_mid_sampled", {63'd0, o_ser_done_sampled}, 64'd0);
        i_ser_done = 1'b0;
        prev_done  = 1'b0;
        i_rst_n    = 1'b1;
        idle();
        idle();
        check("rst_mid_data", o_fifo_data, 64'd0);

        check("pulse_count", 64'(got_pulses), 64'(exp_pulses));
        check("model_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
